// File: rtl/bus_timer.sv
// Memory-mapped machine timer: 64-bit MTIME with prescaler, 64-bit MTIMECMP compare,
// level interrupt, and a 32-byte register window with byte-lane writes and zero-latency reads.
module bus_timer #(
  parameter logic [31:0] BASE_ADDRESS   = 32'hFFFF_FF00,
  parameter logic [31:0] PRESCALE_RESET = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] bus_address,
  input  logic [31:0] bus_write_data,
  input  logic [3:0]  bus_byte_enable,
  input  logic        bus_read_enable,
  input  logic        bus_write_enable,
  output logic [31:0] bus_read_data,
  output logic        timer_irq
);

  localparam logic [2:0] OffMtimeLo = 3'd0;
  localparam logic [2:0] OffMtimeHi = 3'd1;
  localparam logic [2:0] OffCmpLo   = 3'd2;
  localparam logic [2:0] OffCmpHi   = 3'd3;
  localparam logic [2:0] OffCtrl    = 3'd4;
  localparam logic [2:0] OffPre     = 3'd5;

  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic        r_en;
  logic        r_irq_en;
  logic [31:0] r_prescale;
  logic [31:0] r_pcnt;

  logic        w_hit;
  logic [2:0]  w_offset;
  logic [7:0]  w_wr_sel;
  logic        w_tick;
  logic [31:0] w_ctrl_q;
  logic [31:0] w_ctrl_d;
  logic [31:0] w_read_mux;
  logic        w_unused_addr;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strobe);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = strobe[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

  assign w_hit         = (bus_address[31:5] == BASE_ADDRESS[31:5]);
  assign w_offset      = bus_address[4:2];
  assign w_unused_addr = ^bus_address[1:0];
  assign w_wr_sel      = (bus_write_enable && w_hit) ? (8'b1 << w_offset) : 8'b0;
  assign w_tick        = r_en && (r_pcnt == r_prescale);
  assign w_ctrl_q      = {30'b0, r_irq_en, r_en};
  assign w_ctrl_d      = merge_bytes(w_ctrl_q, bus_write_data, bus_byte_enable);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_mtime    <= 64'h0;
      r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      r_en       <= 1'b0;
      r_irq_en   <= 1'b0;
      r_prescale <= PRESCALE_RESET;
      r_pcnt     <= 32'h0;
    end else begin
      // A bus write to either MTIME half swallows a coincident tick for all 64 bits.
      if (w_wr_sel[OffMtimeLo] || w_wr_sel[OffMtimeHi]) begin
        if (w_wr_sel[OffMtimeLo]) begin
          r_mtime[31:0] <= merge_bytes(r_mtime[31:0], bus_write_data, bus_byte_enable);
        end
        if (w_wr_sel[OffMtimeHi]) begin
          r_mtime[63:32] <= merge_bytes(r_mtime[63:32], bus_write_data, bus_byte_enable);
        end
      end else if (w_tick) begin
        r_mtime <= r_mtime + 64'd1;
      end

      if (w_wr_sel[OffCmpLo]) begin
        r_mtimecmp[31:0] <= merge_bytes(r_mtimecmp[31:0], bus_write_data, bus_byte_enable);
      end
      if (w_wr_sel[OffCmpHi]) begin
        r_mtimecmp[63:32] <= merge_bytes(r_mtimecmp[63:32], bus_write_data, bus_byte_enable);
      end

      if (w_wr_sel[OffCtrl]) begin
        r_en     <= w_ctrl_d[0];
        r_irq_en <= w_ctrl_d[1];
      end

      if (w_wr_sel[OffPre]) begin
        r_prescale <= merge_bytes(r_prescale, bus_write_data, bus_byte_enable);
      end

      if (w_wr_sel[OffPre] || (w_wr_sel[OffCtrl] && !r_en && w_ctrl_d[0])) begin
        r_pcnt <= 32'h0;
      end else if (r_en) begin
        r_pcnt <= w_tick ? 32'h0 : r_pcnt + 32'd1;
      end
    end
  end

  always_comb begin
    w_read_mux = 32'h0;
    case (w_offset)
      OffMtimeLo: w_read_mux = r_mtime[31:0];
      OffMtimeHi: w_read_mux = r_mtime[63:32];
      OffCmpLo:   w_read_mux = r_mtimecmp[31:0];
      OffCmpHi:   w_read_mux = r_mtimecmp[63:32];
      OffCtrl:    w_read_mux = w_ctrl_q;
      OffPre:     w_read_mux = r_prescale;
      default:    w_read_mux = 32'h0;
    endcase
  end

  assign bus_read_data = (bus_read_enable && w_hit) ? w_read_mux : 32'h0;
  assign timer_irq     = r_irq_en && (r_mtime >= r_mtimecmp);

endmodule

// File: tb/tb_bus_timer.sv
// Directed self-checking bench for bus_timer: inputs change on the falling edge,
// outputs are sampled 1ns after the falling edge or 1ns after the rising edge.
module tb_bus_timer;

  localparam logic [31:0] Base  = 32'hFFFF_FF00;
  localparam logic [31:0] ALo   = Base + 32'h00;
  localparam logic [31:0] AHi   = Base + 32'h04;
  localparam logic [31:0] ACLo  = Base + 32'h08;
  localparam logic [31:0] ACHi  = Base + 32'h0C;
  localparam logic [31:0] ACtrl = Base + 32'h10;
  localparam logic [31:0] APre  = Base + 32'h14;
  localparam logic [31:0] AOff6 = Base + 32'h18;
  localparam logic [31:0] AOut  = 32'hFFFF_FE14;

  logic        clock;
  logic        reset;
  logic [31:0] bus_address;
  logic [31:0] bus_write_data;
  logic [3:0]  bus_byte_enable;
  logic        bus_read_enable;
  logic        bus_write_enable;
  logic [31:0] bus_read_data;
  logic        timer_irq;

  int n_cmp = 0;
  int n_err = 0;

  bus_timer dut (
    .clock            (clock),
    .reset            (reset),
    .bus_address      (bus_address),
    .bus_write_data   (bus_write_data),
    .bus_byte_enable  (bus_byte_enable),
    .bus_read_enable  (bus_read_enable),
    .bus_write_enable (bus_write_enable),
    .bus_read_data    (bus_read_data),
    .timer_irq        (timer_irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clock);
    bus_address      = a;
    bus_write_data   = d;
    bus_byte_enable  = be;
    bus_write_enable = 1'b1;
    @(posedge clock);
    #1;
    bus_write_enable = 1'b0;
    bus_byte_enable  = 4'h0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d, output logic irq);
    @(negedge clock);
    bus_address     = a;
    bus_read_enable = 1'b1;
    #1;
    d               = bus_read_data;
    irq             = timer_irq;
    bus_read_enable = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        q;
    logic [31:0] addrs [6];
    logic [31:0] exps  [6];
    addrs = '{ALo, AHi, ACLo, ACHi, ACtrl, APre};
    exps  = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0};
    repeat (2) @(posedge clock);
    bus_rd(ACLo, d, q);
    n_cmp++;
    if (d !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL reset_read_during: got %h want ffffffff", d);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus_rd(addrs[i], d, q);
      n_cmp++;
      if (d !== exps[i]) begin
        n_err++;
        $display("FAIL reset_reg%0d: got %h want %h", i, d, exps[i]);
      end
    end
    n_cmp++;
    if (q !== 1'b0) begin
      n_err++;
      $display("FAIL reset_irq: got %b want 0", q);
    end
  endtask

  task automatic test_free_run();
    logic [31:0] d;
    logic        q;
    bus_wr(ACtrl, 32'h1, 4'hF);
    repeat (10) @(posedge clock);
    bus_rd(ALo, d, q);
    n_cmp++;
    if (d !== 32'd10) begin
      n_err++;
      $display("FAIL free_run_lo: got %0d want 10", d);
    end
    bus_rd(AHi, d, q);
    n_cmp++;
    if (d !== 32'd0) begin
      n_err++;
      $display("FAIL free_run_hi: got %0d want 0", d);
    end
  endtask

  task automatic test_carry();
    logic [31:0] d;
    logic        q;
    bus_wr(ACtrl, 32'h0, 4'hF);
    bus_wr(ALo, 32'hFFFF_FFFE, 4'hF);
    bus_wr(AHi, 32'h5, 4'hF);
    bus_wr(APre, 32'h0, 4'hF);
    bus_wr(ACtrl, 32'h1, 4'hF);
    repeat (2) @(posedge clock);
    bus_rd(ALo, d, q);
    n_cmp++;
    if (d !== 32'h0) begin
      n_err++;
      $display("FAIL carry_lo: got %h want 0", d);
    end
    bus_rd(AHi, d, q);
    n_cmp++;
    if (d !== 32'h6) begin
      n_err++;
      $display("FAIL carry_hi: got %h want 6", d);
    end
  endtask

  task automatic test_prescale();
    logic [31:0] d;
    logic [31:0] e;
    logic        q;
    bus_wr(ACtrl, 32'h0, 4'hF);
    bus_wr(ALo, 32'h0, 4'hF);
    bus_wr(AHi, 32'h0, 4'hF);
    bus_wr(APre, 32'h3, 4'hF);
    bus_wr(ACtrl, 32'h1, 4'hF);
    for (int k = 0; k < 10; k++) begin
      e = 32'(k / 4);
      bus_rd(ALo, d, q);
      n_cmp++;
      if (d !== e) begin
        n_err++;
        $display("FAIL prescale3_k%0d: got %0d want %0d", k, d, e);
      end
    end
    bus_wr(APre, 32'h1, 4'hF);
    for (int k = 0; k < 5; k++) begin
      e = 32'(2 + k / 2);
      bus_rd(ALo, d, q);
      n_cmp++;
      if (d !== e) begin
        n_err++;
        $display("FAIL prescale1_k%0d: got %0d want %0d", k, d, e);
      end
    end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    logic        q;
    bus_wr(ACtrl, 32'h0, 4'hF);
    bus_wr(ALo, 32'h0, 4'hF);
    bus_wr(AHi, 32'h0, 4'hF);
    bus_wr(APre, 32'h0, 4'hF);
    bus_wr(ACHi, 32'h0, 4'hF);
    bus_wr(ACLo, 32'd20, 4'hF);
    bus_wr(ACtrl, 32'h3, 4'hF);
    for (int k = 0; k < 23; k++) begin
      bus_rd(ALo, d, q);
      n_cmp++;
      if (d !== 32'(k) || q !== (k >= 20)) begin
        n_err++;
        $display("FAIL irq_k%0d: got mtime=%0d irq=%b want mtime=%0d irq=%b",
                 k, d, q, k, (k >= 20));
      end
    end
    bus_wr(ACHi, 32'h1, 4'hF);
    bus_rd(ALo, d, q);
    n_cmp++;
    if (q !== 1'b0) begin
      n_err++;
      $display("FAIL irq_cmp_raised: got %b want 0", q);
    end
    bus_wr(ACHi, 32'h0, 4'hF);
    bus_rd(ALo, d, q);
    n_cmp++;
    if (q !== 1'b1) begin
      n_err++;
      $display("FAIL irq_cmp_lowered: got %b want 1", q);
    end
    bus_wr(ACtrl, 32'h1, 4'hF);
    bus_rd(ALo, d, q);
    n_cmp++;
    if (q !== 1'b0) begin
      n_err++;
      $display("FAIL irq_en_cleared: got %b want 0", q);
    end
  endtask

  task automatic test_byte_write_and_decode();
    logic [31:0] d;
    logic        q;
    bus_wr(ACtrl, 32'h0, 4'hF);
    bus_wr(ALo, 32'h1234_5678, 4'hF);
    bus_wr(AHi, 32'h0, 4'hF);
    bus_wr(ACtrl, 32'h1, 4'hF);
    bus_wr(ALo, 32'h0000_0064, 4'b0001);
    bus_rd(ALo, d, q);
    n_cmp++;
    if (d !== 32'h1234_5664) begin
      n_err++;
      $display("FAIL byte_write_lo: got %h want 12345664", d);
    end
    bus_wr(ACtrl, 32'h0, 4'hF);
    bus_wr(AOff6, 32'hDEAD_BEEF, 4'hF);
    bus_rd(AOff6, d, q);
    n_cmp++;
    if (d !== 32'h0) begin
      n_err++;
      $display("FAIL offset6_read: got %h want 0", d);
    end
    bus_wr(AOut, 32'h7, 4'hF);
    bus_rd(APre, d, q);
    n_cmp++;
    if (d !== 32'h0) begin
      n_err++;
      $display("FAIL outside_write: got %h want 0", d);
    end
    bus_wr(APre, 32'h9, 4'hF);
    bus_rd(AOut, d, q);
    n_cmp++;
    if (d !== 32'h0) begin
      n_err++;
      $display("FAIL outside_read: got %h want 0", d);
    end
    bus_rd(APre | 32'h3, d, q);
    n_cmp++;
    if (d !== 32'h9) begin
      n_err++;
      $display("FAIL low_addr_bits_ignored: got %h want 9", d);
    end
  endtask

  task automatic test_read_write_same();
    @(negedge clock);
    bus_address      = ACLo;
    bus_write_data   = 32'h55;
    bus_byte_enable  = 4'hF;
    bus_write_enable = 1'b1;
    bus_read_enable  = 1'b1;
    #1;
    n_cmp++;
    if (bus_read_data !== 32'd20) begin
      n_err++;
      $display("FAIL rw_pre_write: got %h want 14", bus_read_data);
    end
    @(posedge clock);
    #1;
    bus_write_enable = 1'b0;
    n_cmp++;
    if (bus_read_data !== 32'h55) begin
      n_err++;
      $display("FAIL rw_post_write: got %h want 55", bus_read_data);
    end
    bus_read_enable = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic        q;
    logic [31:0] addrs [6];
    logic [31:0] exps  [6];
    addrs = '{ALo, AHi, ACLo, ACHi, ACtrl, APre};
    exps  = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0};
    bus_wr(APre, 32'h5, 4'hF);
    bus_wr(ACLo, 32'h0, 4'hF);
    bus_wr(ACHi, 32'h0, 4'hF);
    bus_wr(ACtrl, 32'h3, 4'hF);
    repeat (3) @(posedge clock);
    bus_rd(ALo, d, q);
    n_cmp++;
    if (q !== 1'b1) begin
      n_err++;
      $display("FAIL mid_irq_pending: got %b want 1", q);
    end
    @(negedge clock);
    reset            = 1'b1;
    bus_address      = ALo;
    bus_write_data   = 32'hAAAA_AAAA;
    bus_byte_enable  = 4'hF;
    bus_write_enable = 1'b1;
    @(posedge clock);
    #1;
    bus_write_enable = 1'b0;
    n_cmp++;
    if (timer_irq !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_irq: got %b want 0", timer_irq);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus_rd(addrs[i], d, q);
      n_cmp++;
      if (d !== exps[i]) begin
        n_err++;
        $display("FAIL mid_reset_reg%0d: got %h want %h", i, d, exps[i]);
      end
    end
  endtask

  initial begin
    reset            = 1'b1;
    bus_address      = 32'h0;
    bus_write_data   = 32'h0;
    bus_byte_enable  = 4'h0;
    bus_read_enable  = 1'b0;
    bus_write_enable = 1'b0;
    test_reset();
    test_free_run();
    test_carry();
    test_prescale();
    test_irq();
    test_byte_write_and_decode();
    test_read_write_same();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
